// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the hazard/decode side and the stall controller.
// The master drives the D-stage view and stall/flush requests; the slave
// (stall_ctrl) returns freeze/flush controls, the A-stage register and stats.
interface stall_ctrl_if #(
    parameter int REG_SELECT = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  nop;
    logic                  flush;
    logic                  cnt_clr;
    logic                  valid_d;
    logic                  is_cmp_d;
    logic                  is_write_d;
    logic                  is_load_d;
    logic [REG_SELECT-1:0] reg_a_select_d;
    logic [REG_SELECT-1:0] reg_b_select_d;
    logic [REG_SELECT-1:0] reg_c_select_d;
    logic [DATA_WIDTH-1:0] data_d;

    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  valid_a;
    logic                  is_cmp_a;
    logic                  is_write_a;
    logic                  is_load_a;
    logic [REG_SELECT-1:0] reg_a_select_a;
    logic [REG_SELECT-1:0] reg_b_select_a;
    logic [REG_SELECT-1:0] reg_c_select_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [CNT_WIDTH-1:0]  stall_count;
    logic [CNT_WIDTH-1:0]  flush_count;
    logic                  stall_err;

    modport master (
        output nop, flush, cnt_clr, valid_d, is_cmp_d, is_write_d, is_load_d,
               reg_a_select_d, reg_b_select_d, reg_c_select_d, data_d,
        input  stall_f, stall_d, flush_d, valid_a, is_cmp_a, is_write_a, is_load_a,
               reg_a_select_a, reg_b_select_a, reg_c_select_a, data_a,
               stall_count, flush_count, stall_err
    );

    modport slave (
        input  nop, flush, cnt_clr, valid_d, is_cmp_d, is_write_d, is_load_d,
               reg_a_select_d, reg_b_select_d, reg_c_select_d, data_d,
        output stall_f, stall_d, flush_d, valid_a, is_cmp_a, is_write_a, is_load_a,
               reg_a_select_a, reg_b_select_a, reg_c_select_a, data_a,
               stall_count, flush_count, stall_err
    );
endinterface

// File: rtl/stall_ctrl.sv
// Stall controller: turns the hazard unit's nop request and the branch flush
// into fetch/decode freeze signals, owns the D->A pipeline register (bubbles
// on stall or flush), counts stalls/flushes and flags stalls that run too long.
module stall_ctrl #(
    parameter int REG_SELECT = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_STALL  = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    stall_ctrl_if.slave bus
);

    // Consecutive-stall counter must hold MAX_STALL+1 so an overrun is visible.
    localparam int CW = $clog2(MAX_STALL + 2);
    localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_STALL + 1);
    localparam logic [CW-1:0] CONSEC_LIM = CW'(MAX_STALL);

    typedef enum logic {
        RUN,
        STALLED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   consec;
    logic [CW-1:0]   consec_next;
    logic            stall;
    logic            over_limit;
    logic            stall_err;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    // Stall request is honoured only for a real D instruction and never
    // alongside a flush; reset drops it at once so nothing stays frozen.
    always_comb begin
        stall       = bus.nop & bus.valid_d & ~bus.flush & ~i_rst;
        bus.stall_f = stall;
        bus.stall_d = stall;
        bus.flush_d = bus.flush;
    end

    // D->A register: flush and stall both insert a bubble, otherwise advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.valid_a        <= 1'b0;
            bus.is_cmp_a       <= 1'b0;
            bus.is_write_a     <= 1'b0;
            bus.is_load_a      <= 1'b0;
            bus.reg_a_select_a <= '0;
            bus.reg_b_select_a <= '0;
            bus.reg_c_select_a <= '0;
            bus.data_a         <= '0;
        end else if (bus.flush || stall) begin
            bus.valid_a        <= 1'b0;
            bus.is_cmp_a       <= 1'b0;
            bus.is_write_a     <= 1'b0;
            bus.is_load_a      <= 1'b0;
            bus.reg_a_select_a <= '0;
            bus.reg_b_select_a <= '0;
            bus.reg_c_select_a <= '0;
            bus.data_a         <= '0;
        end else begin
            bus.valid_a        <= bus.valid_d;
            bus.is_cmp_a       <= bus.is_cmp_d & bus.valid_d;
            bus.is_write_a     <= bus.is_write_d & bus.valid_d;
            bus.is_load_a      <= bus.is_load_d & bus.valid_d;
            bus.reg_a_select_a <= bus.reg_a_select_d;
            bus.reg_b_select_a <= bus.reg_b_select_d;
            bus.reg_c_select_a <= bus.reg_c_select_d;
            bus.data_a         <= bus.data_d;
        end
    end

    // FSM state and consecutive-stall count registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= RUN;
            consec <= '0;
        end else begin
            state  <= state_next;
            consec <= consec_next;
        end
    end

    // Next state: flush or a free cycle returns to RUN, stalls count upward.
    always_comb begin
        state_next  = state;
        consec_next = consec;
        if (bus.flush) begin
            state_next  = RUN;
            consec_next = '0;
        end else if (stall) begin
            state_next = STALLED;
            if (state == RUN) begin
                consec_next = CW'(1);
            end else if (consec < CONSEC_MAX) begin
                consec_next = consec + CW'(1);
            end
        end else begin
            state_next  = RUN;
            consec_next = '0;
        end
        over_limit = stall && (consec_next > CONSEC_LIM);
    end

    // Sticky watchdog; a counter clear also acknowledges it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_err <= 1'b0;
        end else if (bus.cnt_clr) begin
            stall_err <= 1'b0;
        end else if (over_limit) begin
            stall_err <= 1'b1;
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (bus.cnt_clr) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
            if (bus.flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

    // Expose the internal statistics registers on the bus.
    always_comb begin
        bus.stall_count = stall_count;
        bus.flush_count = flush_count;
        bus.stall_err   = stall_err;
    end

endmodule
